// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control decoder.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_UNKNOWN
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Moore outputs of the main FSM, one bundle per state
  typedef struct packed {
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/mc_main_fsm.sv
// Multicycle main state machine: state register, next-state logic, Moore decode.
module mc_main_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic       i_bit,
  input  logic       l_bit,
  output ctrl_t      ctrl
);

  state_t state, state_n;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n = S_FETCH;
    case (state)
      S_FETCH:  state_n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  state_n = S_MEMADR;
          OP_DP:   state_n = i_bit ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_n = S_BRANCH;
          default: state_n = S_UNKNOWN;
        endcase
      end
      S_MEMADR:               state_n = l_bit ? S_MEMRD : S_MEMWR;
      S_MEMRD:                state_n = S_MEMWB;
      S_EXECUTER, S_EXECUTEI: state_n = S_ALUWB;
      default:                state_n = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
        ctrl.next_pc    = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = 2'b10;
        ctrl.result_src = 2'b10;
      end
      S_MEMADR:   ctrl.alu_src_b = 2'b01;
      S_MEMRD:    ctrl.adr_src   = 1'b1;
      S_MEMWB: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        ctrl.adr_src = 1'b1;
        ctrl.mem_w   = 1'b1;
      end
      S_EXECUTER: ctrl.alu_op = 1'b1;
      S_EXECUTEI: begin
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = 1'b1;
      end
      S_ALUWB:    ctrl.reg_w = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_b  = 2'b01;
        ctrl.result_src = 2'b10;
        ctrl.branch     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_decoder.sv
// Multicycle ARM control decoder: main FSM, ALU decoder and PC-write detection.
// Condition gating of FlagW/PCS/RegW/MemW happens in the stage downstream.
module mc_decoder
  import mc_ctrl_pkg::*;
#(
  parameter logic [3:0] PC_REG = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  ctrl_t ctrl;

  mc_main_fsm u_fsm (
    .clk   (clk),
    .reset (reset),
    .op    (Op),
    .i_bit (Funct[5]),
    .l_bit (Funct[0]),
    .ctrl  (ctrl)
  );

  assign NextPC    = ctrl.next_pc;
  assign RegW      = ctrl.reg_w;
  assign MemW      = ctrl.mem_w;
  assign IRWrite   = ctrl.ir_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;

  // Instruction-field decodes track Op directly, independent of FSM state
  assign ImmSrc = Op;
  assign RegSrc = {Op == OP_MEM, Op == OP_BR};

  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = 2'b00;
    if (ctrl.alu_op) begin
      case (Funct[4:1])
        CMD_ADD: begin ALUControl = ALU_ADD; FlagW = {2{Funct[0]}};    end
        CMD_SUB: begin ALUControl = ALU_SUB; FlagW = {2{Funct[0]}};    end
        CMD_AND: begin ALUControl = ALU_AND; FlagW = {Funct[0], 1'b0}; end
        CMD_ORR: begin ALUControl = ALU_ORR; FlagW = {Funct[0], 1'b0}; end
        default: begin ALUControl = ALU_ADD; FlagW = 2'b00;            end
      endcase
    end
  end

  assign PCS = ((Rd == PC_REG) && ctrl.reg_w) || ctrl.branch;

endmodule

// File: tb/tb_mc_decoder.sv
// Randomized bench for mc_decoder against a per-instruction phase-sequence model.
module tb_mc_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [1:0] FlagW, ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct packed {
    logic [1:0] flagw;
    logic       pcs, nextpc, regw, memw, irwrite, adrsrc;
    logic [1:0] resultsrc;
    logic       alusrca;
    logic [1:0] alusrcb, immsrc, regsrc, aluctl;
  } outs_t;

  mc_decoder dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic outs_t observed();
    outs_t o;
    o = {FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc,
         ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};
    return o;
  endfunction

  // Expected outputs for one named instruction phase, straight from the phase tables
  function automatic outs_t model(input string ph, input logic [1:0] op,
                                  input logic [5:0] fn, input logic [3:0] rd);
    outs_t o;
    logic [3:0] cmd;
    logic       known;
    o = '0;
    cmd = fn[4:1];
    o.immsrc = op;
    o.regsrc = {op == 2'b01, op == 2'b10};
    if (ph == "FETCH") begin
      o.irwrite = 1; o.alusrca = 1; o.alusrcb = 2'b10; o.resultsrc = 2'b10; o.nextpc = 1;
    end else if (ph == "DECODE") begin
      o.alusrca = 1; o.alusrcb = 2'b10; o.resultsrc = 2'b10;
    end else if (ph == "MEMADR") begin
      o.alusrcb = 2'b01;
    end else if (ph == "MEMRD") begin
      o.adrsrc = 1;
    end else if (ph == "MEMWB") begin
      o.resultsrc = 2'b01; o.regw = 1; o.pcs = (rd == 4'd15);
    end else if (ph == "MEMWR") begin
      o.adrsrc = 1; o.memw = 1;
    end else if (ph == "EXECR" || ph == "EXECI") begin
      o.alusrcb = (ph == "EXECI") ? 2'b01 : 2'b00;
      known = (cmd == 4'd4) || (cmd == 4'd2) || (cmd == 4'd0) || (cmd == 4'd12);
      if (cmd == 4'd4)  o.aluctl = 2'd0;
      if (cmd == 4'd2)  o.aluctl = 2'd1;
      if (cmd == 4'd0)  o.aluctl = 2'd2;
      if (cmd == 4'd12) o.aluctl = 2'd3;
      if (known && fn[0]) o.flagw = (cmd == 4'd4 || cmd == 4'd2) ? 2'b11 : 2'b10;
    end else if (ph == "ALUWB") begin
      o.regw = 1; o.pcs = (rd == 4'd15);
    end else if (ph == "BRANCH") begin
      o.alusrcb = 2'b01; o.resultsrc = 2'b10; o.pcs = 1;
    end
    return o;
  endfunction

  // Runs one instruction from its FETCH cycle; abort_at = phase index after which reset hits
  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn,
                           input logic [3:0] rd, input int abort_at);
    string ph[$];
    Op = op; Funct = fn; Rd = rd;
    ph = {"FETCH", "DECODE"};
    case (op)
      2'b01: begin
        ph.push_back("MEMADR");
        if (fn[0]) begin ph.push_back("MEMRD"); ph.push_back("MEMWB"); end
        else ph.push_back("MEMWR");
      end
      2'b00: begin ph.push_back(fn[5] ? "EXECI" : "EXECR"); ph.push_back("ALUWB"); end
      2'b10: ph.push_back("BRANCH");
      default: ph.push_back("UNKNOWN");
    endcase
    for (int i = 0; i < ph.size(); i++) begin
      @(negedge clk);
      check($sformatf("%s op=%0d fn=%02h rd=%0d", ph[i], op, fn, rd),
            32'(observed()), 32'(model(ph[i], op, fn, rd)));
      if (i == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int abort_at;
    logic [3:0] rd;
    reset = 1'b1; Op = 2'b00; Funct = 6'b0; Rd = 4'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", 32'(observed()), 32'(model("FETCH", 2'b00, 6'b0, 4'b0)));
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(2'b01, 6'b011001, 4'd3,  -1);  // LDR
    run_instr(2'b01, 6'b011000, 4'd3,  -1);  // STR
    run_instr(2'b00, 6'b001001, 4'd2,  -1);  // ADDS reg
    run_instr(2'b00, 6'b111000, 4'd4,  -1);  // ORR imm
    run_instr(2'b00, 6'b100101, 4'd15, -1);  // SUBS imm to PC
    run_instr(2'b10, 6'b000000, 4'd0,  -1);  // B
    run_instr(2'b11, 6'b000000, 4'd0,  -1);  // undefined op
    run_instr(2'b01, 6'b011001, 4'd15, 3);   // LDR, reset during MEMRD
    run_instr(2'b00, 6'b000001, 4'd15, -1);  // ANDS after abort

    for (int n = 0; n < 400; n++) begin
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(2'($urandom), 6'($urandom), rd, abort_at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
